// File: rtl/esp8266_frame_rx_pkg.sv
// Shared constants and state encodings for the ESP8266 receive path.
package esp8266_frame_rx_pkg;

   localparam logic [7:0] HDR0 = 8'hFF;
   localparam logic [7:0] HDR1 = 8'hFE;
   localparam logic [7:0] HDR2 = 8'hFD;
   localparam logic [7:0] HDR3 = 8'hFC;
   localparam int         FRAME_LEN = 9;

   typedef enum logic [3:0] {H0, H1, H2, H3, D1, D2, D3, D4, CK} parse_state_t;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;

endpackage

// File: rtl/esp8266_frame_rx_uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, stop-bit check.
module uart_byte_rx
   import esp8266_frame_rx_pkg::*;
#(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frm_err
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

   // [0] metastability flop, [1] synchronised line, [2] previous sample for edge detect
   logic [2:0]    rx_pipe;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   wire rx      = rx_pipe[1];
   wire rx_prev = rx_pipe[2];

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_pipe    <= 3'b111;
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frm_err    <= 1'b0;
      end else begin
         rx_pipe    <= {rx_pipe[1:0], uart_rx};
         byte_valid <= 1'b0;
         frm_err    <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (rx_prev && !rx) begin
                  state <= RX_START;
                  cnt   <= '0;
               end
            end
            RX_START: begin
               if (cnt == HALF) begin
                  cnt <= '0;
                  if (rx) state <= RX_IDLE;
                  else begin
                     state   <= RX_DATA;
                     bit_idx <= '0;
                  end
               end else cnt <= cnt + 1'b1;
            end
            RX_DATA: begin
               if (cnt == FULL) begin
                  cnt     <= '0;
                  shreg   <= {rx, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end else cnt <= cnt + 1'b1;
            end
            RX_STOP: begin
               if (cnt == FULL) begin
                  cnt <= '0;
                  if (rx) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shreg;
                     state      <= RX_IDLE;
                  end else begin
                     frm_err <= 1'b1;
                     state   <= RX_WAIT_HI;
                  end
               end else cnt <= cnt + 1'b1;
            end
            RX_WAIT_HI: if (rx) state <= RX_IDLE;
            default:    state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/esp8266_frame_rx.sv
// Hunts for FF FE FD FC d1 d2 d3 d4 x frames and presents XOR-checked payload.
// Optional inter-byte idle timeout: define ESP_RX_TIMEOUT_EN.
module esp8266_frame_rx
   import esp8266_frame_rx_pkg::*;
#(
   parameter int BAUD_DIV     = 434,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic [7:0] d1,
   output logic [7:0] d2,
   output logic [7:0] d3,
   output logic [7:0] d4,
   output logic       frame_valid,
   output logic       chk_err,
   output logic       frm_err
);

   if (BAUD_DIV < 16) begin : g_bad_baud
      $error("BAUD_DIV must be at least 16");
   end
   if (TIMEOUT_BITS < 1) begin : g_bad_tmo
      $error("TIMEOUT_BITS must be at least 1");
   end

   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            rx_frm_err;
   logic            tmo_hit;
   parse_state_t    state;
   logic [7:0]      xor_acc;
   logic [3:0][7:0] shadow;

   uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frm_err    (rx_frm_err)
   );

   assign frm_err = rx_frm_err;

`ifdef ESP_RX_TIMEOUT_EN
   localparam int TMO_CYC = TIMEOUT_BITS * BAUD_DIV;
   localparam int TW      = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst) tmo_cnt <= '0;
      else if (byte_valid || state == H0) tmo_cnt <= '0;
      else if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (tmo_cnt == TW'(TMO_CYC));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= H0;
         xor_acc     <= '0;
         shadow      <= '0;
         d1          <= '0;
         d2          <= '0;
         d3          <= '0;
         d4          <= '0;
         frame_valid <= 1'b0;
         chk_err     <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         chk_err     <= 1'b0;
         if (rx_frm_err) state <= H0;
         else if (byte_valid) begin
            // Header states fall back to H1 on FF so a repeated FF never loses sync
            case (state)
               H0: state <= (byte_data == HDR0) ? H1 : H0;
               H1: state <= (byte_data == HDR1) ? H2 : (byte_data == HDR0) ? H1 : H0;
               H2: state <= (byte_data == HDR2) ? H3 : (byte_data == HDR0) ? H1 : H0;
               H3: begin
                  if (byte_data == HDR3) begin
                     state   <= D1;
                     xor_acc <= '0;
                  end else state <= (byte_data == HDR0) ? H1 : H0;
               end
               D1: begin shadow[0] <= byte_data; xor_acc <= xor_acc ^ byte_data; state <= D2; end
               D2: begin shadow[1] <= byte_data; xor_acc <= xor_acc ^ byte_data; state <= D3; end
               D3: begin shadow[2] <= byte_data; xor_acc <= xor_acc ^ byte_data; state <= D4; end
               D4: begin shadow[3] <= byte_data; xor_acc <= xor_acc ^ byte_data; state <= CK; end
               CK: begin
                  if (byte_data == xor_acc) begin
                     d1          <= shadow[0];
                     d2          <= shadow[1];
                     d3          <= shadow[2];
                     d4          <= shadow[3];
                     frame_valid <= 1'b1;
                  end else chk_err <= 1'b1;
                  state <= H0;
               end
               default: state <= H0;
            endcase
         end else if (tmo_hit) state <= H0;
      end
   end

endmodule

// File: doc/esp8266_frame_rx.md
# esp8266_frame_rx

Receive-side counterpart of the ESP8266 send path. Deserialises the UART stream from the ESP8266 and hunts for the 9-byte frame `FF FE FD FC d1 d2 d3 d4 x`, where `x = d1^d2^d3^d4`. It checks the XOR and presents the four payload bytes to the tracker/control logic with a one-cycle valid strobe. It sits between the `uart_rx` pin and the consumer of remote commands or coordinates.

## Interface
- `BAUD_DIV`, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 16.
- `TIMEOUT_BITS`, 20: inter-byte idle limit in bit-times; used only when the timeout is compiled in.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input; idles high.
- `d1`,`d2`,`d3`,`d4`  out  8 each  payload of the last good frame; held until the next good frame.
- `frame_valid`  out  1  one-cycle pulse; `d1..d4` updated in the same cycle.
- `chk_err`  out  1  one-cycle pulse when a complete frame fails the XOR check.
- `frm_err`  out  1  one-cycle pulse when a byte has a bad stop bit.

## Operation
- **Byte receiver**
  - `uart_rx` passes through a 2-flop synchroniser.
  - A high→low transition in idle starts a bit counter.
  - The start bit is re-sampled at `BAUD_DIV/2`; if it is high, the start is false and the receiver returns to idle.
  - 8 data bits are sampled LSB first, then the stop bit, each `BAUD_DIV` cycles apart.
  - Stop = 1: a `byte_valid` pulse is issued with the byte.
  - Stop = 0: `frm_err` pulses, no byte is issued, and the receiver waits for the line to go high before re-arming.
- **Frame parser FSM**
  - States: `H0`, `H1`, `H2`, `H3`, `D1`, `D2`, `D3`, `D4`, `CK`. The FSM acts only on `byte_valid`.
  - `H0`: FF→`H1`; anything else stays in `H0`.
  - `H1`: FE→`H2`; FF stays in `H1`; anything else →`H0`.
  - `H2`: FD→`H3`; FF→`H1`; anything else →`H0`.
  - `H3`: FC→`D1`; FF→`H1`; anything else →`H0`.
  - `D1`..`D4`: capture each byte into a shadow register and fold it into a running XOR; advance to the next state.
  - `CK`: if the byte equals the running XOR, copy the shadow registers to `d1..d4` and pulse `frame_valid`; otherwise pulse `chk_err` and leave `d1..d4` unchanged. Either way →`H0`.
- Payload bytes are not header-checked; a payload or checksum byte of FF is legal.
- `frm_err` during any state sends the parser to `H0` (the frame is dropped).
- Reset values: all outputs 0; FSM in `H0`; byte receiver idle; running XOR 0.
- `rst` has priority over every other event. Reset mid-byte or mid-frame discards partial data with no error pulse.

## Timing
- `byte_valid` is issued 1 cycle after the stop-bit sample (synchroniser delay is 2 cycles).
- `frame_valid` / `chk_err` rise 1 cycle after the checksum byte's `byte_valid`. Each is high for exactly 1 cycle.
- `d1..d4` change only on the `frame_valid` cycle.
- Back-to-back frames with zero idle between them are accepted; throughput is limited only by the line rate.
- The receiver re-arms for a new start bit in the cycle after the stop-bit sample.

## Configuration
- `ESP_RX_TIMEOUT_EN`
  - Defined: a counter clears on every `byte_valid`. If the FSM is outside `H0` and `TIMEOUT_BITS*BAUD_DIV` cycles elapse with no byte, the FSM returns to `H0` silently.
  - Undefined: there is no counter, and a partial frame waits indefinitely for its next byte.

## Structure
- Shared package holds:
  - header constants `HDR0..HDR3` = FF/FE/FD/FC;
  - the parser state encoding;
  - the frame length constant (9).
- One sub-module: `uart_byte_rx` (synchroniser, bit timing, framing check), with outputs `byte_valid`, `byte_data`, `frm_err`. The parser FSM, XOR and output registers live in the top level.

## Test plan
- Send `FF FE FD FC 12 34 56 78 08` → one `frame_valid` pulse; `d1..d4` = 12/34/56/78; no error pulses.
- Same frame with the last byte 09 → one `chk_err` pulse; `d1..d4` keep their previous values; a following good frame (with payload AA/55/00/FF) is accepted.
- Send `FF FF FE FD FC 01 02 03 04 04` → the repeated FF is absorbed; `frame_valid` fires; `d1..d4` = 01/02/03/04.
- Send a frame with stop bit 0 on byte `d2` → `frm_err` pulses and no `frame_valid` occurs; the next clean frame is accepted.
- Assert `rst` for 1 cycle after `d3` is received, then send a full good frame → the partial frame produces no pulse; the full frame is accepted; outputs are 0 immediately after reset.
- With `ESP_RX_TIMEOUT_EN` defined: send the header plus `d1`, then idle for 20 bit-times, then send `FF FE FD FC 11 22 33 44 44` → exactly one `frame_valid`, with `d1..d4` = 11/22/33/44.
